// File: rtl/datapath_core_stall.sv
// Parametrised datapath core: register file, ALU, PC, IR and status flags, with a
// request/ready memory port whose three-state access FSM stalls the control word.
module datapath_core_stall #(
    parameter int                    DATA_WIDTH = 64,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    NUM_REGS   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cw_valid,
    input  logic                  AS,
    input  logic [1:0]            DS,
    input  logic [1:0]            PS,
    input  logic                  PC_Sel,
    input  logic                  K_Sel,
    input  logic                  IL,
    input  logic                  SL,
    input  logic                  MW,
    input  logic                  RW,
    input  logic [3:0]            FS,
    input  logic                  C0,
    input  logic [4:0]            DA,
    input  logic [4:0]            SA,
    input  logic [4:0]            SB,
    input  logic [DATA_WIDTH-1:0] K,
    output logic [3:0]            SF,
    output logic [31:0]           IR_Out,
    output logic                  stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready
);
    localparam int         SHW      = $clog2(DATA_WIDTH);
    localparam logic [4:0] ZERO_REG = 5'(NUM_REGS - 1);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t                state, state_next;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [ADDR_WIDTH-1:0] pc, pc_next, pc_in;
    logic [DATA_WIDTH-1:0] mdr;
    logic [DATA_WIDTH-1:0] a, b, b_op, addend, f, d;
    logic [DATA_WIDTH:0]   sum;
    logic                  c_out, v_out;
    logic [3:0]            flags;
    logic                  mem_op, commit;

    // Register NUM_REGS-1 and above are hardwired zero on read.
    assign a    = (SA >= ZERO_REG) ? '0 : regs[SA];
    assign b    = (SB >= ZERO_REG) ? '0 : regs[SB];
    assign b_op = K_Sel ? K : b;

    // FS[0] distinguishes add (0100) from subtract-style add (0101).
    assign addend = FS[0] ? ~b_op : b_op;
    assign sum    = {1'b0, a} + {1'b0, addend} + {{DATA_WIDTH{1'b0}}, C0};

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        f     = '0;
        c_out = 1'b0;
        v_out = 1'b0;
        case (FS)
            4'b0000: f = a & b_op;
            4'b0001: f = a | b_op;
            4'b0010: f = a ^ b_op;
            4'b0011: f = ~a;
            4'b0100, 4'b0101: begin
                f     = sum[DATA_WIDTH-1:0];
                c_out = sum[DATA_WIDTH];
                v_out = (a[DATA_WIDTH-1] == addend[DATA_WIDTH-1]) &&
                        (sum[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
            end
            4'b0110: f = a;
            4'b0111: f = b_op;
            4'b1000: f = a << b_op[SHW-1:0];
            4'b1001: f = a >> b_op[SHW-1:0];
            default: f = '0;
        endcase
    end

    assign flags = {v_out, c_out, f[DATA_WIDTH-1], (f == '0)};

    always_comb begin
        d = f;
        case (DS)
            2'b00:   d = f;
            2'b01:   d = b;
            2'b10:   d = DATA_WIDTH'(pc);
            default: d = mdr;
        endcase
    end

    assign pc_in = PC_Sel ? ADDR_WIDTH'(K) : ADDR_WIDTH'(a);

    always_comb begin
        pc_next = pc;
        case (PS)
            2'b00:   pc_next = pc;
            2'b01:   pc_next = pc + ADDR_WIDTH'(4);
            2'b10:   pc_next = pc_in;
            default: pc_next = pc + ADDR_WIDTH'(K << 2);
        endcase
    end

    assign mem_addr  = AS ? ADDR_WIDTH'(f) : pc;
    assign mem_wdata = b;
    assign mem_op    = cw_valid & (MW | (DS == 2'b11));
    assign commit    = cw_valid & ~stall;

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op) begin
                    stall      = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                mem_we  = MW;
                if (mem_ready) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            IR_Out <= '0;
            SF     <= '0;
            mdr    <= '0;
            // NOTE: the register file is cleared on reset, so it maps to flops rather than RAM.
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            state <= state_next;
            if (state == REQ && mem_ready) mdr <= mem_rdata;
            if (commit) begin
                if (RW && DA < ZERO_REG) regs[DA] <= d;
                if (IL) IR_Out <= d[31:0];
                if (SL) SF <= flags;
                pc <= pc_next;
            end
        end
    end
endmodule

// File: tb/tb_datapath_core_stall.sv
// Self-checking bench for datapath_core_stall: scoreboard queues hold expected memory
// requests and register results, popped when the DUT presents them.
module tb_datapath_core_stall;
    localparam int              DW  = 64;
    localparam int              AW  = 32;
    localparam logic [AW-1:0]   RPC = 32'h0000_0100;

    logic          clk = 1'b0;
    logic          rst;
    logic          cw_valid, AS, PC_Sel, K_Sel, IL, SL, MW, RW, C0;
    logic [1:0]    DS, PS;
    logic [3:0]    FS;
    logic [4:0]    DA, SA, SB;
    logic [DW-1:0] K;
    logic [3:0]    SF;
    logic [31:0]   IR_Out;
    logic          stall, mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_ready;

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
    } mem_exp_t;

    mem_exp_t      mem_q[$];
    logic [DW-1:0] res_q[$];
    int            total = 0;
    int            bad   = 0;
    int            cyc, stl, rqs;

    datapath_core_stall #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(32), .RESET_PC(RPC)
    ) dut (
        .clk(clk), .rst(rst), .cw_valid(cw_valid), .AS(AS), .DS(DS), .PS(PS),
        .PC_Sel(PC_Sel), .K_Sel(K_Sel), .IL(IL), .SL(SL), .MW(MW), .RW(RW),
        .FS(FS), .C0(C0), .DA(DA), .SA(SA), .SB(SB), .K(K), .SF(SF),
        .IR_Out(IR_Out), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic clear_cw();
        cw_valid = 0; AS = 0; DS = 0; PS = 0; PC_Sel = 0; K_Sel = 0;
        IL = 0; SL = 0; MW = 0; RW = 0; C0 = 0; FS = 0;
        DA = 0; SA = 5'd31; SB = 5'd31; K = '0;
    endtask

    // Pops the next expected register value and compares it with reg[r] seen on mem_wdata.
    task automatic check_reg(input string tag, input logic [4:0] r);
        logic [DW-1:0] exp_v;
        exp_v = (res_q.size() > 0) ? res_q.pop_front() : 'x;
        SB = r;
        #1;
        check(tag, mem_wdata, exp_v);
    endtask

    task automatic check_pc(input string tag, input logic [AW-1:0] exp);
        logic as_save;
        as_save = AS;
        AS = 1'b0;
        #1;
        check(tag, DW'(mem_addr), DW'(exp));
        AS = as_save;
    endtask

    // Issues the current control word and serves the memory port until it commits.
    task automatic run_word(input int delay, input logic [DW-1:0] rdata,
                            output int cycles, output int stalls, output int reqs);
        mem_exp_t e;
        bit       have_e = 0;
        bit       done   = 0;
        int       waited = 0;
        cycles = 0; stalls = 0; reqs = 0;
        cw_valid = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            #1;
            if (mem_req) begin
                if (!have_e) begin
                    if (mem_q.size() > 0) e = mem_q.pop_front();
                    else begin e.addr = 'x; e.we = 1'bx; e.wdata = 'x; end
                    have_e = 1;
                end
                check("req_addr", DW'(mem_addr), DW'(e.addr));
                check("req_we", DW'(mem_we), DW'(e.we));
                check("req_wdata", mem_wdata, e.wdata);
                mem_ready = (waited >= delay);
                mem_rdata = rdata;
                waited++;
                reqs++;
            end
            if (stall) stalls++;
            done = !stall;
            cycles++;
            @(posedge clk);
            @(negedge clk);
            mem_ready = 1'b0;
            mem_rdata = '0;
        end
        if (!done) check("commit_timeout", 64'd0, 64'd1);
        cw_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear_cw();
        mem_ready = 1'b0;
        mem_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ir", DW'(IR_Out), 64'd0);
        check("rst_sf", DW'(SF), 64'd0);
        check("rst_stall", DW'(stall), 64'd0);
        check("rst_req", DW'({mem_req, mem_we}), 64'd0);
        check_pc("rst_pc", RPC);
        res_q.push_back(64'd0);
        check_reg("rst_reg5", 5'd5);

        // Pass K into reg3: single-cycle, never stalls.
        @(negedge clk); clear_cw();
        RW = 1; DA = 3; K_Sel = 1; K = 64'd5; FS = 4'b0111; DS = 2'b00;
        res_q.push_back(64'd5);
        run_word(0, '0, cyc, stl, rqs);
        check("w1_cycles", 64'(cyc), 64'd1);
        check("w1_stalls", 64'(stl), 64'd0);
        check_reg("w1_reg3", 5'd3);

        @(negedge clk); clear_cw();
        RW = 1; DA = 1; K_Sel = 1; K = 64'h7FFF_FFFF_FFFF_FFFF; FS = 4'b0111;
        res_q.push_back(64'h7FFF_FFFF_FFFF_FFFF);
        run_word(0, '0, cyc, stl, rqs);
        check_reg("w2_reg1", 5'd1);

        // Signed overflow on add.
        @(negedge clk); clear_cw();
        SA = 1; K_Sel = 1; K = 64'd1; FS = 4'b0100; SL = 1; RW = 1; DA = 2;
        res_q.push_back(64'h8000_0000_0000_0000);
        run_word(0, '0, cyc, stl, rqs);
        check_reg("add_reg2", 5'd2);
        check("add_sf", DW'(SF), 64'b1010);

        // 5 - 5 via A + ~B' + 1: zero with carry out.
        @(negedge clk); clear_cw();
        SA = 3; K_Sel = 1; K = 64'd5; FS = 4'b0101; C0 = 1; SL = 1;
        run_word(0, '0, cyc, stl, rqs);
        check("sub_sf", DW'(SF), 64'b0101);

        @(negedge clk); clear_cw();
        SA = 2; K_Sel = 1; K = 64'hC000_0000_0000_0000; FS = 4'b0000; SL = 1; RW = 1; DA = 4;
        res_q.push_back(64'h8000_0000_0000_0000);
        run_word(0, '0, cyc, stl, rqs);
        check_reg("and_reg4", 5'd4);
        check("and_sf", DW'(SF), 64'b0010);

        // Shift amount uses only the low 6 bits of K (68 -> 4); SL=0 keeps flags.
        @(negedge clk); clear_cw();
        SA = 3; K_Sel = 1; K = 64'd68; FS = 4'b1000; RW = 1; DA = 6;
        res_q.push_back(64'd80);
        run_word(0, '0, cyc, stl, rqs);
        check_reg("shl_reg6", 5'd6);
        check("shl_sf_hold", DW'(SF), 64'b0010);

        @(negedge clk); clear_cw();
        SA = 2; SB = 1; K_Sel = 0; FS = 4'b1001; RW = 1; DA = 7;
        res_q.push_back(64'd1);
        run_word(0, '0, cyc, stl, rqs);
        check_reg("shr_reg7", 5'd7);

        @(negedge clk); clear_cw();
        RW = 1; DA = 9; K_Sel = 1; K = 64'hDEAD; FS = 4'b0111;
        res_q.push_back(64'hDEAD);
        run_word(0, '0, cyc, stl, rqs);
        check_reg("ld_reg9", 5'd9);

        @(negedge clk); clear_cw();
        RW = 1; DA = 11; DS = 2'b10;
        res_q.push_back(64'(RPC));
        run_word(0, '0, cyc, stl, rqs);
        check_reg("ds_pc_reg11", 5'd11);

        // Instruction fetch with two wait states.
        @(negedge clk); clear_cw();
        AS = 0; DS = 2'b11; IL = 1; PS = 2'b01; RW = 1; DA = 8; SB = 9;
        mem_q.push_back('{addr: RPC, we: 1'b0, wdata: 64'hDEAD});
        res_q.push_back(64'h8B02_0020);
        run_word(2, 64'h8B02_0020, cyc, stl, rqs);
        check("fetch_stalls", 64'(stl), 64'd4);
        check("fetch_reqs", 64'(rqs), 64'd3);
        check("fetch_cycles", 64'(cyc), 64'd5);
        check("fetch_ir", DW'(IR_Out), 64'h8B02_0020);
        check_pc("fetch_pc", RPC + 32'd4);
        check_reg("fetch_reg8", 5'd8);

        // Store with immediate ready.
        @(negedge clk); clear_cw();
        SA = 31; K_Sel = 1; K = 64'h100; FS = 4'b0100; AS = 1; MW = 1; SB = 9;
        mem_q.push_back('{addr: 32'h100, we: 1'b1, wdata: 64'hDEAD});
        run_word(0, '0, cyc, stl, rqs);
        check("store_reqs", 64'(rqs), 64'd1);
        check("store_cycles", 64'(cyc), 64'd3);
        check("store_q_empty", 64'(mem_q.size()), 64'd0);

        // Read-during-write of the same register sees the old value.
        @(negedge clk); clear_cw();
        RW = 1; DA = 9; SB = 9; K_Sel = 1; K = 64'h77; FS = 4'b0111;
        cw_valid = 1;
        #1;
        check("rdw_old", mem_wdata, 64'hDEAD);
        res_q.push_back(64'h77);
        run_word(0, '0, cyc, stl, rqs);
        check_reg("rdw_new", 5'd9);

        // cw_valid=0: nothing commits, no stall.
        @(negedge clk); clear_cw();
        RW = 1; DA = 9; K_Sel = 1; K = 64'h99; FS = 4'b0111; DS = 2'b11; MW = 1;
        repeat (2) @(negedge clk);
        #1;
        check("novalid_stall", DW'(stall), 64'd0);
        res_q.push_back(64'h77);
        check_reg("novalid_reg9", 5'd9);

        // F truncates onto the narrower address bus.
        @(negedge clk); clear_cw();
        AS = 1; K_Sel = 1; K = 64'h1234_5678_9ABC_DEF0; FS = 4'b0111;
        #1;
        check("addr_trunc", DW'(mem_addr), 64'h9ABC_DEF0);

        // PC load then PC+(K<<2) wrap-around.
        @(negedge clk); clear_cw();
        PS = 2'b10; PC_Sel = 1; K = 64'hFFFF_FFFC;
        run_word(0, '0, cyc, stl, rqs);
        check_pc("pc_load", 32'hFFFF_FFFC);
        @(negedge clk); clear_cw();
        PS = 2'b11; K = 64'd1;
        run_word(0, '0, cyc, stl, rqs);
        check_pc("pc_wrap", 32'h0000_0000);

        @(negedge clk); clear_cw();
        RW = 1; DA = 31; K_Sel = 1; K = 64'h55; FS = 4'b0111;
        res_q.push_back(64'd0);
        run_word(0, '0, cyc, stl, rqs);
        check_reg("reg31_zero", 5'd31);

        // Reset while a request is outstanding; a late ready must be ignored.
        @(negedge clk); clear_cw();
        AS = 0; DS = 2'b11; IL = 1; PS = 2'b01; RW = 1; DA = 3;
        cw_valid = 1;
        #1;
        check("rr_idle_stall", DW'({stall, mem_req}), 64'b10);
        @(posedge clk); @(negedge clk);
        #1;
        check("rr_in_req", DW'(mem_req), 64'd1);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        #1;
        check("rr_req_drop", DW'(mem_req), 64'd0);
        rst = 1'b0;
        clear_cw();
        mem_ready = 1'b1;
        mem_rdata = 64'hBAD0_BAD0;
        @(posedge clk); @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check("rr_late_ready", DW'({mem_req, stall}), 64'd0);
        check("rr_ir", DW'(IR_Out), 64'd0);
        check_pc("rr_pc", RPC);
        res_q.push_back(64'd0);
        check_reg("rr_reg3", 5'd3);

        @(negedge clk); clear_cw();
        RW = 1; DA = 3; K_Sel = 1; K = 64'h42; FS = 4'b0111;
        res_q.push_back(64'h42);
        run_word(0, '0, cyc, stl, rqs);
        check("rr_after_cycles", 64'(cyc), 64'd1);
        check_reg("rr_after_reg3", 5'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/datapath_core_stall.md
# datapath_core_stall

Parametrised successor to the single-cycle datapath core: register file, ALU, program counter, instruction register and status flags, with data width, address width and register count set by parameters. Internal buses are multiplexed rather than tri-stated. Memory is reached through an external request/ready port with arbitrary wait states. A three-state access FSM stalls the control unit while an access is outstanding. The block sits between the control unit, which supplies the control word, and the memory subsystem.

## Interface
- DATA_WIDTH, 64, register/ALU/data-bus width (≥32)
- ADDR_WIDTH, 32, PC and memory address width
- NUM_REGS, 32, register count (≤32); register NUM_REGS-1 reads as zero
- RESET_PC, 0, PC value after reset
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- cw_valid  in  1  control word below is valid this cycle
- AS  in  1  address select: 0 PC, 1 ALU result
- DS  in  2  data select: 00 ALU F, 01 B, 10 PC (zero-extended), 11 memory read data
- PS  in  2  PC function: 00 hold, 01 PC+4, 10 load PC_in, 11 PC+(K<<2)
- PC_Sel  in  1  PC_in source: 0 A, 1 K
- K_Sel  in  1  ALU B operand: 0 B, 1 K
- IL, SL, MW, RW  in  1 each  IR load, status load, memory write, register write
- FS  in  4  ALU function
- C0  in  1  ALU carry-in
- DA, SA, SB  in  5 each  register addresses
- K  in  DATA_WIDTH  constant
- SF  out  4  status {V,C,N,Z}
- IR_Out  out  32  instruction register
- stall  out  1  control word must be held unchanged
- mem_req, mem_we  out  1 each  memory request, write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  write data (register B)
- mem_rdata  in  DATA_WIDTH  read data
- mem_ready  in  1  access complete this cycle

## Operation
- A = reg[SA], B = reg[SB], combinational reads. Addresses ≥ NUM_REGS-1 read 0. Writes to them are ignored.
- ALU operand B' = K_Sel ? K : B.
- FS: 0000 AND, 0001 OR, 0010 XOR, 0011 NOT A, 0100 A+B'+C0, 0101 A+~B'+C0, 0110 pass A, 0111 pass B', 1000 A<<B'[log2 DATA_WIDTH-1:0], 1001 logical right shift, others F=0.
- Flags: Z=(F==0), N=F[MSB]. C is the carry-out and V the signed overflow, for FS 0100/0101 only; both are 0 otherwise.
- mem_addr = AS ? F[ADDR_WIDTH-1:0] : PC. Truncated when wider, zero-extended when narrower.
- mem_op = cw_valid & (MW | DS==11).
- commit = cw_valid & ~stall. At commit:
  - RW writes D to reg[DA].
  - IL loads IR ← D[31:0].
  - SL loads SF.
  - PS updates the PC.
  - Without commit, all state holds.
- FSM states: IDLE, REQ, DONE.
  - IDLE: if mem_op, stall=1 and next state is REQ. Otherwise stall=0 and the word commits in one cycle.
  - REQ: mem_req=1, mem_we=MW, stall=1. On mem_ready, capture mem_rdata into MDR and go to DONE. For writes, the write completes on that edge.
  - DONE: stall=0, commit using MDR as the DS=11 source, next state IDLE.
- Arithmetic is modulo 2^width. PC+4 and PC+(K<<2) wrap at ADDR_WIDTH.

## Timing
- Reset values:
  - PC=RESET_PC, IR_Out=0, SF=0.
  - Registers: 0.
  - MDR: 0.
  - FSM=IDLE.
  - mem_req=0, mem_we=0.
- stall is combinational from state and mem_op.
- Non-memory word: latency 1; commits at the edge ending the cycle.
- Memory word: minimum 3 cycles (IDLE, REQ with mem_ready=1, DONE). Each cycle mem_ready stays low in REQ adds one cycle.
- mem_addr, mem_we and mem_wdata are stable while mem_req=1, because the control unit holds the word during stall.
- mem_ready is ignored outside REQ.
- rst during REQ or DONE:
  - Next edge returns to IDLE with mem_req=0 and no commit.
  - A late mem_ready is ignored.
- cw_valid=0 in IDLE: no commit, stall=0.
- The control word must not change while stall=1. Behaviour is undefined if it does.
- Read-during-write of the same register returns the old value in that cycle.

## Test plan
- Reset, then a word with RW=1, DA=3, K_Sel=1, K=5, FS=0110 with SA=31 (OR pass A=0; use FS=0111), DS=00 → reg3=5 after 1 cycle, stall=0 throughout.
- ADD: reg1=0x7FFF_FFFF_FFFF_FFFF plus K=1, SL=1 → F=0x8000_0000_0000_0000, SF={V=1,C=0,N=1,Z=0}.
- Fetch: AS=0, DS=11, IL=1, PS=01, mem_ready delayed 2 cycles, rdata=0x8B02_0020 → stall high for 4 cycles, IR=0x8B02_0020, PC=RESET_PC+4 after DONE.
- Store: MW=1, AS=1, address F=0x100, B=0xDEAD, mem_ready immediate → mem_req=1 for exactly 1 cycle, mem_we=1, mem_wdata=0xDEAD, 3-cycle latency.
- Reset asserted in REQ with mem_ready=0 → mem_req=0 next cycle, PC=RESET_PC, no register write, mem_ready pulse afterwards ignored.
- PS=11 with PC=0xFFFF_FFFC, K=1 → PC wraps to 0x0000_0000. A write to DA=31 → reads 0.
